// File: rtl/fp_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fp_pkg : single-precision format constants and int_to_fp state encoding
// Revision 1.0
// ----------------------------------------------------------------------------
package fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = 127;

  // Exponent of a 32-bit magnitude whose leading one sits at bit 31.
  localparam logic [FP_EXP_W-1:0] I2F_EXP_INIT = FP_EXP_W'(FP_BIAS + 31);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } i2f_state_t;

endpackage
`default_nettype wire

// File: rtl/fp_rne_round.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fp_rne_round : round-to-nearest-even of a normalised 32-bit magnitude
// Revision 1.0
// ----------------------------------------------------------------------------
module fp_rne_round
  import fp_pkg::*;
(
  input  logic [31:0]         mag,
  input  logic [FP_EXP_W-1:0] exp_in,
  output logic [FP_MAN_W-1:0] frac,
  output logic [FP_EXP_W-1:0] exp_out,
  output logic                inexact
);

  logic guard;
  logic sticky;
  logic round_up;
  logic mant_all_ones;

  always_comb begin
    guard         = mag[7];
    sticky        = |mag[6:0];
    round_up      = guard & (sticky | mag[8]);
    mant_all_ones = &mag[31:8];
    inexact       = |mag[7:0];
    frac          = mag[30:8];
    exp_out       = exp_in;
    // A carry out of the 24-bit mantissa renormalises to 1.0 at the next exponent.
    if (round_up && mant_all_ones) begin
      frac    = '0;
      exp_out = exp_in + FP_EXP_W'(1);
    end else if (round_up) begin
      frac = mag[30:8] + 23'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/int_to_fp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// int_to_fp : 32-bit integer to IEEE-754 single, iterative normalise, RNE
// Revision 1.0
// ----------------------------------------------------------------------------
module int_to_fp
  import fp_pkg::*;
#(
  parameter int NORM_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_inexact
);

  localparam logic [FP_EXP_W-1:0] STEP_EXP = FP_EXP_W'(NORM_STEP);

  i2f_state_t          state_q, state_d;
  logic [31:0]         mag_q, mag_d;
  logic [FP_EXP_W-1:0] exp_q, exp_d;
  logic                sign_q, sign_d;
  logic [31:0]         out_data_q, out_data_d;
  logic                out_inexact_q, out_inexact_d;

  logic                in_sign;
  logic [31:0]         in_mag;
  logic [FP_MAN_W-1:0] rnd_frac;
  logic [FP_EXP_W-1:0] rnd_exp;
  logic                rnd_inexact;

  assign in_ready    = (state_q == IDLE) & ~rst;
  assign out_valid   = (state_q == DONE);
  assign out_data    = out_data_q;
  assign out_inexact = out_inexact_q;

  // Signed 0x80000000 negates to itself, which is already the right magnitude.
  assign in_sign = in_signed & in_data[31];
  assign in_mag  = in_sign ? (32'd0 - in_data) : in_data;

  fp_rne_round u_round (
    .mag     (mag_q),
    .exp_in  (exp_q),
    .frac    (rnd_frac),
    .exp_out (rnd_exp),
    .inexact (rnd_inexact)
  );

  always_comb begin
    state_d       = state_q;
    mag_d         = mag_q;
    exp_d         = exp_q;
    sign_d        = sign_q;
    out_data_d    = out_data_q;
    out_inexact_d = out_inexact_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sign_d = in_sign;
          mag_d  = in_mag;
          exp_d  = I2F_EXP_INIT;
          if (in_mag == 32'd0) begin
            out_data_d    = 32'h0000_0000;
            out_inexact_d = 1'b0;
            state_d       = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (mag_q[31]) begin
          state_d = ROUND;
        end else if (mag_q[31 -: NORM_STEP] == '0) begin
          mag_d = mag_q << NORM_STEP;
          exp_d = exp_q - STEP_EXP;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - FP_EXP_W'(1);
        end
      end
      ROUND: begin
        out_data_d    = {sign_q, rnd_exp, rnd_frac};
        out_inexact_d = rnd_inexact;
        state_d       = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mag_q         <= '0;
      exp_q         <= '0;
      sign_q        <= 1'b0;
      out_data_q    <= '0;
      out_inexact_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mag_q         <= mag_d;
      exp_q         <= exp_d;
      sign_q        <= sign_d;
      out_data_q    <= out_data_d;
      out_inexact_q <= out_inexact_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_int_to_fp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_int_to_fp : directed-vector bench for int_to_fp (NORM_STEP = 4)
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_int_to_fp;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_inexact;

  int n_checks = 0;
  int n_pass   = 0;

  int_to_fp #(.NORM_STEP(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_signed   (in_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_inexact (out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Latency 1 means out_valid is already high just after the accept edge.
  task automatic send(input logic [31:0] d, input logic s, input bit consume,
                      output int lat, output logic [31:0] od, output logic oi);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    in_valid  = 1'b1;
    in_data   = d;
    in_signed = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 32'h0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    od = out_data;
    oi = out_inexact;
    if (consume) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b, expected 0", in_ready);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if (out_data !== 32'h0 || out_inexact !== 1'b0)
      $display("FAIL reset_outputs: got data %h inexact %b, expected 00000000 0", out_data, out_inexact);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b, expected 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_one();
    int lat; logic [31:0] od; logic oi;
    send(32'h0000_0001, 1'b1, 1'b1, lat, od, oi);
    n_checks++;
    if (od !== 32'h3F80_0000 || oi !== 1'b0)
      $display("FAIL one_signed: got %h/%b, expected 3f800000/0", od, oi);
    else n_pass++;
    n_checks++;
    if (lat !== 13) $display("FAIL one_latency: got %0d, expected 13", lat);
    else n_pass++;
  endtask

  task automatic test_all_ones();
    int lat; logic [31:0] od; logic oi;
    send(32'hFFFF_FFFF, 1'b1, 1'b1, lat, od, oi);
    n_checks++;
    if (od !== 32'hBF80_0000 || oi !== 1'b0 || lat !== 13)
      $display("FAIL minus_one: got %h/%b lat %0d, expected bf800000/0 lat 13", od, oi, lat);
    else n_pass++;
    send(32'hFFFF_FFFF, 1'b0, 1'b1, lat, od, oi);
    n_checks++;
    if (od !== 32'h4F80_0000 || oi !== 1'b1 || lat !== 3)
      $display("FAIL max_unsigned_carry: got %h/%b lat %0d, expected 4f800000/1 lat 3", od, oi, lat);
    else n_pass++;
  endtask

  task automatic test_min_int();
    int lat; logic [31:0] od; logic oi;
    send(32'h8000_0000, 1'b1, 1'b1, lat, od, oi);
    n_checks++;
    if (od !== 32'hCF00_0000 || oi !== 1'b0 || lat !== 3)
      $display("FAIL min_int_signed: got %h/%b lat %0d, expected cf000000/0 lat 3", od, oi, lat);
    else n_pass++;
    send(32'h8000_0000, 1'b0, 1'b1, lat, od, oi);
    n_checks++;
    if (od !== 32'h4F00_0000 || oi !== 1'b0 || lat !== 3)
      $display("FAIL min_int_unsigned: got %h/%b lat %0d, expected 4f000000/0 lat 3", od, oi, lat);
    else n_pass++;
  endtask

  task automatic test_ties();
    int lat; logic [31:0] od; logic oi;
    // lz = 7: one 4-step plus three 1-steps, latency 3 + 4.
    send(32'h0100_0001, 1'b0, 1'b1, lat, od, oi);
    n_checks++;
    if (od !== 32'h4B80_0000 || oi !== 1'b1 || lat !== 7)
      $display("FAIL tie_even_down: got %h/%b lat %0d, expected 4b800000/1 lat 7", od, oi, lat);
    else n_pass++;
    send(32'h0100_0003, 1'b1, 1'b1, lat, od, oi);
    n_checks++;
    if (od !== 32'h4B80_0002 || oi !== 1'b1 || lat !== 7)
      $display("FAIL tie_odd_up: got %h/%b lat %0d, expected 4b800002/1 lat 7", od, oi, lat);
    else n_pass++;
  endtask

  task automatic test_zero_hold();
    int lat; logic [31:0] od; logic oi;
    send(32'h0000_0000, 1'b1, 1'b0, lat, od, oi);
    n_checks++;
    if (od !== 32'h0 || oi !== 1'b0 || lat !== 1)
      $display("FAIL zero: got %h/%b lat %0d, expected 00000000/0 lat 1", od, oi, lat);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h0 || in_ready !== 1'b0)
        $display("FAIL zero_hold cycle %0d: got valid %b data %h in_ready %b, expected 1 00000000 0",
                 i, out_valid, out_data, in_ready);
      else n_pass++;
    end
    // Input offered in the same cycle as out_ready must not be taken.
    in_valid  = 1'b1;
    in_data   = 32'h0000_0005;
    in_signed = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL done_no_accept: got in_ready %b out_valid %b, expected 1 0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] od; logic oi;
    bit seen;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 32'h0000_0001;
    in_signed = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL mid_reset_idle: got in_ready %b out_valid %b, expected 1 0", in_ready, out_valid);
    else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL mid_reset_discard: got out_valid seen %b, expected 0", seen);
    else n_pass++;
    send(32'h0000_0007, 1'b0, 1'b1, lat, od, oi);
    n_checks++;
    if (od !== 32'h40E0_0000 || oi !== 1'b0 || lat !== 11)
      $display("FAIL after_reset_seven: got %h/%b lat %0d, expected 40e00000/0 lat 11", od, oi, lat);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] od; logic oi;
    send(32'hFFFF_FFF9, 1'b1, 1'b1, lat, od, oi);
    n_checks++;
    if (od !== 32'hC0E0_0000 || oi !== 1'b0 || lat !== 11)
      $display("FAIL b2b_minus_seven: got %h/%b lat %0d, expected c0e00000/0 lat 11", od, oi, lat);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL b2b_turnaround: got in_ready %b, expected 1", in_ready);
    else n_pass++;
    send(32'h0000_0100, 1'b0, 1'b1, lat, od, oi);
    n_checks++;
    if (od !== 32'h4380_0000 || oi !== 1'b0 || lat !== 11)
      $display("FAIL b2b_256: got %h/%b lat %0d, expected 43800000/0 lat 11", od, oi, lat);
    else n_pass++;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_signed = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_one();
    test_all_ones();
    test_min_int();
    test_ties();
    test_zero_hold();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
